// File: rtl/module_bin2bcd_seq_if.sv
// Handshake and data bundle between a binary source and the bin2bcd converter.
// The converter takes the slave side; the source/display side takes the master side.
interface module_bin2bcd_seq_if #(
  parameter int unsigned W_BIN    = 27,
  parameter int unsigned N_DIGITS = 8
);
  logic                  start_i;
  logic [W_BIN-1:0]      bin_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  ovf_o;
  logic [4*N_DIGITS-1:0] bcd_o;

  modport master (
    output start_i,
    output bin_i,
    input  busy_o,
    input  done_o,
    input  ovf_o,
    input  bcd_o
  );

  modport slave (
    input  start_i,
    input  bin_i,
    output busy_o,
    output done_o,
    output ovf_o,
    output bcd_o
  );
endinterface

// File: rtl/module_bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter (double dabble, one bit per clock).
// Results saturate to all-nines with ovf_o set when the input exceeds the display range.
module module_bin2bcd_seq #(
  parameter int unsigned W_BIN    = 27,
  parameter int unsigned N_DIGITS = 8
) (
  input  logic                  clk_10Mhz_i,
  input  logic                  reset_i,
  module_bin2bcd_seq_if.slave   bus
);
  localparam int unsigned BCD_W   = 4 * N_DIGITS;
  localparam int unsigned CNT_W   = (W_BIN > 1) ? $clog2(W_BIN) : 1;
  localparam logic [63:0] MAX_VAL = 64'(10 ** N_DIGITS) - 64'd1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [W_BIN-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_flag_q, ovf_flag_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  always_ff @(posedge clk_10Mhz_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    adj        = '0;

    // Per-nibble add-3 correction; no carry crosses a nibble boundary.
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                    : scratch_q[4*i +: 4];
    end

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          bin_d      = bus.bin_i;
          scratch_d  = '0;
          ovf_flag_d = (64'(bus.bin_i) > MAX_VAL);
          cnt_d      = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W_BIN - 1)) state_d = DONE;
      end
      DONE: begin
        // Outputs are registered here, so done_o/bcd_o appear the cycle after DONE.
        bcd_d   = ovf_flag_q ? {N_DIGITS{4'h9}} : scratch_q;
        ovf_d   = ovf_flag_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy_o = (state_q != IDLE);
  assign bus.done_o = done_q;
  assign bus.ovf_o  = ovf_q;
  assign bus.bcd_o  = bcd_q;
endmodule

// File: tb/tb_module_bin2bcd_seq.sv
// Directed bench for module_bin2bcd_seq: latency, boundaries, lockout and reset abort.
module tb_module_bin2bcd_seq;
  localparam int unsigned W_BIN    = 27;
  localparam int unsigned N_DIGITS = 8;
  localparam int unsigned LAT      = W_BIN + 1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  module_bin2bcd_seq_if #(.W_BIN(W_BIN), .N_DIGITS(N_DIGITS)) bus ();

  module_bin2bcd_seq #(.W_BIN(W_BIN), .N_DIGITS(N_DIGITS)) dut (
    .clk_10Mhz_i (clk),
    .reset_i     (rst),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a start pulse; returns just after the acceptance edge.
  task automatic launch(input logic [W_BIN-1:0] val);
    bus.bin_i   = val;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
  endtask

  // Cycles from acceptance to done_o, bounded; busy_n counts busy samples on the way.
  task automatic wait_done(output int cycles, output int busy_n);
    cycles = 0;
    busy_n = (bus.busy_o === 1'b1) ? 1 : 0;
    while (bus.done_o !== 1'b1 && cycles < 60) begin
      step();
      cycles++;
      if (bus.busy_o === 1'b1) busy_n++;
    end
  endtask

  int cyc, busy_n, done_n;

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.bin_i   = '0;
    #1;
    chk("reset_bcd",  64'(bus.bcd_o),  64'h0);
    chk("reset_done", 64'(bus.done_o), 64'h0);
    chk("reset_busy", 64'(bus.busy_o), 64'h0);
    chk("reset_ovf",  64'(bus.ovf_o),  64'h0);
    step();
    step();
    rst = 1'b0;
    step();

    // Zero: latency and busy duration
    launch(27'd0);
    wait_done(cyc, busy_n);
    chk("zero_latency", 64'(cyc),       64'(LAT));
    chk("zero_busy",    64'(busy_n),    64'(LAT));
    chk("zero_bcd",     64'(bus.bcd_o), 64'h0);
    chk("zero_ovf",     64'(bus.ovf_o), 64'h0);
    step();
    chk("zero_done_pulse", 64'(bus.done_o), 64'h0);

    // Full-width value, input changed after acceptance
    launch(27'd12_345_678);
    bus.bin_i = 27'd5;
    wait_done(cyc, busy_n);
    chk("mid_latency", 64'(cyc),       64'(LAT));
    chk("mid_bcd",     64'(bus.bcd_o), 64'h12345678);
    chk("mid_ovf",     64'(bus.ovf_o), 64'h0);
    step();

    launch(27'd100_000_000);
    wait_done(cyc, busy_n);
    chk("ovf1e8_bcd", 64'(bus.bcd_o), 64'h99999999);
    chk("ovf1e8_ovf", 64'(bus.ovf_o), 64'h1);
    step();

    launch(27'd99_999_999);
    wait_done(cyc, busy_n);
    chk("max_bcd", 64'(bus.bcd_o), 64'h99999999);
    chk("max_ovf", 64'(bus.ovf_o), 64'h0);
    step();

    launch(27'd134_217_727);
    wait_done(cyc, busy_n);
    chk("allones_bcd", 64'(bus.bcd_o), 64'h99999999);
    chk("allones_ovf", 64'(bus.ovf_o), 64'h1);
    step();

    // Busy lockout: starts at cycle 5 and in DONE are ignored; held start accepted next IDLE edge
    launch(27'd42);
    done_n = 0;
    for (int n = 1; n <= 28; n++) begin
      step();
      if (bus.done_o === 1'b1) done_n++;
      if (n == 10) chk("hold_bcd_during_conv", 64'(bus.bcd_o), 64'h99999999);
      if (n == 4) begin bus.bin_i = 27'd7; bus.start_i = 1'b1; end
      if (n == 5) bus.start_i = 1'b0;
      if (n == 27) begin bus.bin_i = 27'd7; bus.start_i = 1'b1; end
    end
    chk("lock_done_count", 64'(done_n),     64'd1);
    chk("lock_done_at28",  64'(bus.done_o), 64'h1);
    chk("lock_bcd",        64'(bus.bcd_o),  64'h42);
    step();
    bus.start_i = 1'b0;
    chk("held_start_busy", 64'(bus.busy_o), 64'h1);
    chk("held_start_done", 64'(bus.done_o), 64'h0);
    wait_done(cyc, busy_n);
    chk("held_latency", 64'(cyc),       64'(LAT));
    chk("held_bcd",     64'(bus.bcd_o), 64'h7);
    step();

    // Reset mid-conversion, asserted between edges
    launch(27'd87_654_321);
    for (int n = 1; n < 10; n++) step();
    #20;
    rst = 1'b1;
    #1;
    chk("async_rst_bcd",  64'(bus.bcd_o),  64'h0);
    chk("async_rst_busy", 64'(bus.busy_o), 64'h0);
    chk("async_rst_done", 64'(bus.done_o), 64'h0);
    chk("async_rst_ovf",  64'(bus.ovf_o),  64'h0);
    step();
    step();
    rst = 1'b0;
    done_n = 0;
    busy_n = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (bus.done_o === 1'b1) done_n++;
      if (bus.busy_o === 1'b1) busy_n++;
    end
    chk("abort_no_done", 64'(done_n),    64'd0);
    chk("abort_idle",    64'(busy_n),    64'd0);
    chk("abort_bcd",     64'(bus.bcd_o), 64'h0);

    launch(27'd9);
    wait_done(cyc, busy_n);
    chk("post_rst_latency", 64'(cyc),       64'(LAT));
    chk("post_rst_bcd",     64'(bus.bcd_o), 64'h9);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
